// File: rtl/add3_arb_if.sv
// add3_arb_if: requester beats, datapath operands/results and tagged responses of the add3 arbiter
interface add3_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_last;
    logic [23:0] req0_act;
    logic [23:0] req0_wgt;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_last;
    logic [23:0] req1_act;
    logic [23:0] req1_wgt;
    logic [7:0]  dp_act_0;
    logic [7:0]  dp_act_1;
    logic [7:0]  dp_act_2;
    logic [7:0]  dp_wgt_0;
    logic [7:0]  dp_wgt_1;
    logic [7:0]  dp_wgt_2;
    logic [31:0] dp_psum_0;
    logic [31:0] dp_psum_1;
    logic [31:0] dp_psum_2;
    logic [95:0] rsp_psum;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp_last;
    logic        busy;
    modport slave (
        input  req0_valid, req0_last, req0_act, req0_wgt,
        input  req1_valid, req1_last, req1_act, req1_wgt,
        input  dp_psum_0, dp_psum_1, dp_psum_2,
        output req0_ready, req1_ready,
        output dp_act_0, dp_act_1, dp_act_2, dp_wgt_0, dp_wgt_1, dp_wgt_2,
        output rsp_psum, rsp0_valid, rsp1_valid, rsp_last, busy
    );
    modport master (
        output req0_valid, req0_last, req0_act, req0_wgt,
        output req1_valid, req1_last, req1_act, req1_wgt,
        output dp_psum_0, dp_psum_1, dp_psum_2,
        input  req0_ready, req1_ready,
        input  dp_act_0, dp_act_1, dp_act_2, dp_wgt_0, dp_wgt_1, dp_wgt_2,
        input  rsp_psum, rsp0_valid, rsp1_valid, rsp_last, busy
    );
endinterface

// File: rtl/add3_arb.sv
// add3_arb: round-robin burst arbiter feeding the add3 datapath and returning tagged psums after LAT cycles
module add3_arb #(
    parameter int unsigned LAT = 1,
    parameter int unsigned GAP = 2
) (
    input logic       clk,
    input logic       rst,
    add3_arb_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    typedef struct packed {
        logic valid;
        logic owner;
        logic last;
    } tag_t;
    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         ptr_q, ptr_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [23:0]  act_q, act_d;
    logic [23:0]  wgt_q, wgt_d;
    tag_t [LAT:0] tag_q;
    tag_t         push;
    logic         own_valid, own_last, accept, in_flight;
    logic [23:0]  own_act, own_wgt;
    always_comb begin
        own_valid = owner_q ? bus_io.req1_valid : bus_io.req0_valid;
        own_last  = owner_q ? bus_io.req1_last : bus_io.req0_last;
        own_act   = owner_q ? bus_io.req1_act : bus_io.req0_act;
        own_wgt   = owner_q ? bus_io.req1_wgt : bus_io.req0_wgt;
        accept    = state_q == BURST && own_valid;
        act_d     = accept ? own_act : '0;
        wgt_d     = accept ? own_wgt : '0;
        push      = '{valid: accept, owner: owner_q, last: accept && own_last};
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE && (bus_io.req0_valid || bus_io.req1_valid)) begin
            state_d = BURST;
            owner_d = (bus_io.req0_valid && bus_io.req1_valid) ? ptr_q : bus_io.req1_valid;
        end
        if (accept && own_last) begin
            state_d = (GAP == 0) ? IDLE : DRAIN;
            ptr_d   = ~owner_q;
            cnt_d   = 4'(GAP - 1);
        end
        if (state_q == DRAIN) begin
            state_d = (cnt_q == 4'd0) ? IDLE : DRAIN;
            cnt_d   = cnt_q - 4'd1;
        end
    end
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i <= int'(LAT); i++) in_flight = in_flight | tag_q[i].valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            tag_q   <= {tag_q[LAT-1:0], push};
        end
    end
    assign bus_io.req0_ready = state_q == BURST && !owner_q;
    assign bus_io.req1_ready = state_q == BURST && owner_q;
    assign bus_io.dp_act_0   = act_q[7:0];
    assign bus_io.dp_act_1   = act_q[15:8];
    assign bus_io.dp_act_2   = act_q[23:16];
    assign bus_io.dp_wgt_0   = wgt_q[7:0];
    assign bus_io.dp_wgt_1   = wgt_q[15:8];
    assign bus_io.dp_wgt_2   = wgt_q[23:16];
    assign bus_io.rsp_psum   = {bus_io.dp_psum_2, bus_io.dp_psum_1, bus_io.dp_psum_0};
    // The oldest tag stage lines up with the datapath result for the same beat
    assign bus_io.rsp0_valid = tag_q[LAT].valid && !tag_q[LAT].owner;
    assign bus_io.rsp1_valid = tag_q[LAT].valid && tag_q[LAT].owner;
    assign bus_io.rsp_last   = tag_q[LAT].valid && tag_q[LAT].last;
    assign bus_io.busy       = state_q != IDLE || in_flight;
endmodule

// File: tb/tb_add3_arb.sv
// tb_add3_arb: two arbiter instances (LAT=1/GAP=2 and LAT=3/GAP=0) checked every cycle against a timing model
module tb_add3_arb;
    typedef struct {
        logic [23:0] a;
        logic [23:0] w;
        logic        l;
        int          gap;
    } beat_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld [2][2];
    logic        lst [2][2];
    logic [23:0] act [2][2];
    logic [23:0] wgt [2][2];
    logic [31:0] psum [2][3];
    logic        rdy [2][2];
    logic [7:0]  dpa [2][3];
    logic [7:0]  dpw [2][3];
    logic [95:0] rsp [2];
    logic        rv [2][2];
    logic        rl [2];
    logic        bsy [2];
    int          checks = 0;
    int          failures = 0;
    int          c = 0;
    int          rc [2][2];
    int          both_cnt [2];
    int          last_cnt [2];
    int          own [2];
    int          ptr [2];
    int          idle_from [2];
    int          last_acc [2];
    logic        sv [2][16];
    logic        so [2][16];
    logic        sl [2][16];
    logic [23:0] ea [2];
    logic [23:0] ew [2];
    beat_t       q [2][2][$];

    always #5 clk = ~clk;

    add3_arb_if bus [2] ();
    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].req0_valid = vld[g][0];
        assign bus[g].req0_last  = lst[g][0];
        assign bus[g].req0_act   = act[g][0];
        assign bus[g].req0_wgt   = wgt[g][0];
        assign bus[g].req1_valid = vld[g][1];
        assign bus[g].req1_last  = lst[g][1];
        assign bus[g].req1_act   = act[g][1];
        assign bus[g].req1_wgt   = wgt[g][1];
        assign bus[g].dp_psum_0  = psum[g][0];
        assign bus[g].dp_psum_1  = psum[g][1];
        assign bus[g].dp_psum_2  = psum[g][2];
        assign rdy[g][0] = bus[g].req0_ready;
        assign rdy[g][1] = bus[g].req1_ready;
        assign dpa[g][0] = bus[g].dp_act_0;
        assign dpa[g][1] = bus[g].dp_act_1;
        assign dpa[g][2] = bus[g].dp_act_2;
        assign dpw[g][0] = bus[g].dp_wgt_0;
        assign dpw[g][1] = bus[g].dp_wgt_1;
        assign dpw[g][2] = bus[g].dp_wgt_2;
        assign rsp[g]    = bus[g].rsp_psum;
        assign rv[g][0]  = bus[g].rsp0_valid;
        assign rv[g][1]  = bus[g].rsp1_valid;
        assign rl[g]     = bus[g].rsp_last;
        assign bsy[g]    = bus[g].busy;
        add3_arb #(.LAT(g == 0 ? 1 : 3), .GAP(g == 0 ? 2 : 0)) u_dut (
            .clk(clk), .rst(rst), .bus_io(bus[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        own[k] = -1;
        ptr[k] = 0;
        idle_from[k] = c;
        last_acc[k] = -100;
        ea[k] = '0;
        ew[k] = '0;
        for (int s = 0; s < 16; s++) sv[k][s] = 1'b0;
        q[k][0].delete();
        q[k][1].delete();
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            rc[k][0] = 0;
            rc[k][1] = 0;
            both_cnt[k] = 0;
            last_cnt[k] = 0;
        end
    endtask

    task automatic push_beat(input int r, input logic [23:0] a, input logic [23:0] w, input logic l, input int gap);
        beat_t b;
        b.a = a;
        b.w = w;
        b.l = l;
        b.gap = gap;
        q[0][r].push_back(b);
        q[1][r].push_back(b);
    endtask

    task automatic add_burst(input int r, input int n, input int pct, input int hole);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (i == hole) ? 1 : (($urandom() % 100) < pct ? int'($urandom_range(1, 2)) : 0);
            push_beat(r, 24'($urandom()), 24'($urandom()), i == n - 1, gap);
        end
    endtask

    // One accepted beat or one grant decision per cycle, derived from the burst/gap/pointer rules
    task automatic advance(input int k);
        beat_t b;
        int o;
        o = own[k];
        ea[k] = '0;
        ew[k] = '0;
        if (o >= 0 && vld[k][o]) begin
            b = q[k][o].pop_front();
            ea[k] = b.a;
            ew[k] = b.w;
            last_acc[k] = c;
            sv[k][(c + 1 + lat_of(k)) % 16] = 1'b1;
            so[k][(c + 1 + lat_of(k)) % 16] = (o == 1);
            sl[k][(c + 1 + lat_of(k)) % 16] = b.l;
            if (b.l) begin
                ptr[k] = 1 - o;
                own[k] = -1;
                idle_from[k] = c + 1 + gap_of(k);
            end
        end else if (o < 0 && c >= idle_from[k] && (vld[k][0] || vld[k][1])) begin
            own[k] = (vld[k][0] && vld[k][1]) ? ptr[k] : (vld[k][1] ? 1 : 0);
        end
    endtask

    task automatic tick();
        beat_t b;
        logic  bz;
        int    s;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                vld[k][r] = 1'b0;
                act[k][r] = 24'($urandom());
                wgt[k][r] = 24'($urandom());
                lst[k][r] = 1'($urandom());
                if (q[k][r].size() > 0) begin
                    b = q[k][r][0];
                    if (b.gap > 0) begin
                        b.gap--;
                        q[k][r][0] = b;
                    end else begin
                        vld[k][r] = 1'b1;
                        act[k][r] = b.a;
                        wgt[k][r] = b.w;
                        lst[k][r] = b.l;
                    end
                end
            end
            for (int i = 0; i < 3; i++) psum[k][i] = $urandom();
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            s = c % 16;
            chkb($sformatf("i%0d_c%0d_ready0", k, c), rdy[k][0], own[k] == 0);
            chkb($sformatf("i%0d_c%0d_ready1", k, c), rdy[k][1], own[k] == 1);
            chk($sformatf("i%0d_c%0d_dp_act", k, c), 96'({dpa[k][2], dpa[k][1], dpa[k][0]}), 96'(ea[k]));
            chk($sformatf("i%0d_c%0d_dp_wgt", k, c), 96'({dpw[k][2], dpw[k][1], dpw[k][0]}), 96'(ew[k]));
            chk($sformatf("i%0d_c%0d_rsp_psum", k, c), rsp[k], {psum[k][2], psum[k][1], psum[k][0]});
            chkb($sformatf("i%0d_c%0d_rsp0", k, c), rv[k][0], sv[k][s] && !so[k][s]);
            chkb($sformatf("i%0d_c%0d_rsp1", k, c), rv[k][1], sv[k][s] && so[k][s]);
            chkb($sformatf("i%0d_c%0d_rsp_last", k, c), rl[k], sv[k][s] && sl[k][s]);
            bz = own[k] >= 0 || c < idle_from[k] || last_acc[k] >= c - 1 - lat_of(k);
            chkb($sformatf("i%0d_c%0d_busy", k, c), bsy[k], bz);
            rc[k][0] += int'(rv[k][0]);
            rc[k][1] += int'(rv[k][1]);
            both_cnt[k] += int'(rv[k][0] && rv[k][1]);
            last_cnt[k] += int'(rl[k]);
            sv[k][s] = 1'b0;
            if (rst) model_reset(k);
            else advance(k);
        end
        c++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        run(2);
        rst = 1'b0;
        run(3);
        // single beat, LAT=1 GAP=2 instance checked against fixed values
        push_beat(0, 24'h030201, 24'h060504, 1'b1, 0);
        run(2);
        chk("s1_dp_act", 96'({dpa[0][2], dpa[0][1], dpa[0][0]}), 96'h030201);
        chk("s1_dp_wgt", 96'({dpw[0][2], dpw[0][1], dpw[0][0]}), 96'h060504);
        tick();
        chkb("s1_rsp0", rv[0][0], 1'b1);
        chkb("s1_rsp_last", rl[0], 1'b1);
        chk("s1_dp_zero", 96'({dpa[0][2], dpa[0][1], dpa[0][0]}), 96'h0);
        run(12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // both requesters with two 3-beat bursts each
        clear_counts();
        add_burst(0, 3, 0, -1);
        add_burst(0, 3, 0, -1);
        add_burst(1, 3, 0, -1);
        add_burst(1, 3, 0, -1);
        run(45);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s2_i%0d_rsp0_count", k), 96'(rc[k][0]), 96'd6);
            chk($sformatf("s2_i%0d_rsp1_count", k), 96'(rc[k][1]), 96'd6);
            chk($sformatf("s2_i%0d_both", k), 96'(both_cnt[k]), 96'd0);
        end
        // 4-beat burst with a bubble in beat 2's slot
        clear_counts();
        add_burst(0, 4, 0, 1);
        run(20);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s3_i%0d_rsp0_count", k), 96'(rc[k][0]), 96'd4);
            chk($sformatf("s3_i%0d_last_count", k), 96'(last_cnt[k]), 96'd1);
        end
        // back-to-back single beats from req0 then req1
        clear_counts();
        push_beat(0, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        tick();
        push_beat(1, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        run(14);
        chk("s4_i1_rsp0_count", 96'(rc[1][0]), 96'd1);
        chk("s4_i1_rsp1_count", 96'(rc[1][1]), 96'd1);
        // reset with two beats in flight
        add_burst(0, 6, 0, -1);
        run(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_counts();
        run(10);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s5_i%0d_rsp_after_rst", k), 96'(rc[k][0] + rc[k][1]), 96'd0);
            chk($sformatf("s5_i%0d_dp_zero", k), 96'({dpa[k][2], dpa[k][1], dpa[k][0]}), 96'h0);
        end
        push_beat(0, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        push_beat(1, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        tick();
        chkb("s5_grant0", rdy[0][0], 1'b1);
        chkb("s5_no_grant1", rdy[0][1], 1'b0);
        run(20);
        // req1 alone while the pointer favours req0, then pointer back on req0
        push_beat(1, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        tick();
        chkb("s6_grant1_alone", rdy[0][1], 1'b1);
        run(10);
        push_beat(0, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        push_beat(1, 24'($urandom()), 24'($urandom()), 1'b1, 0);
        tick();
        chkb("s6_ptr_back0", rdy[0][0], 1'b1);
        run(20);
        // random bursts with random valid gaps
        clear_counts();
        repeat (500) begin
            for (int r = 0; r < 2; r++)
                if (q[0][r].size() == 0 && ($urandom() % 4) == 0) add_burst(r, int'($urandom_range(1, 5)), 25, -1);
            tick();
        end
        run(60);
        for (int k = 0; k < 2; k++) chk($sformatf("rand_i%0d_both", k), 96'(both_cnt[k]), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
